// File: rtl/score_keeper_if.sv
// Game-event and score-display bundle between the game logic and score_keeper.
// The master drives the event pulses and the slave (score_keeper) drives the registered results.
interface score_keeper_if;
  logic        game_start;
  logic        eat_1;
  logic        eat_2;
  logic        bonus_1;
  logic        bonus_2;
  logic        crash_1;
  logic        crash_2;
  logic [15:0] score_1;
  logic [15:0] score_2;
  logic [15:0] high_score;
  logic [1:0]  state;
  logic [1:0]  winner;
  logic        round_over;

  modport master (
    output game_start, eat_1, eat_2, bonus_1, bonus_2, crash_1, crash_2,
    input  score_1, score_2, high_score, state, winner, round_over
  );

  modport slave (
    input  game_start, eat_1, eat_2, bonus_1, bonus_2, crash_1, crash_2,
    output score_1, score_2, high_score, state, winner, round_over
  );
endinterface

// File: rtl/score_keeper.sv
// Per-player score accumulation, round state machine, winner decision and session high score.
// Every output comes straight from a register, so the display never sees intermediate values.
module score_keeper #(
  parameter int MAX_SCORE    = 99,
  parameter int FOOD_POINTS  = 1,
  parameter int BONUS_POINTS = 5,
  parameter int WIN_SCORE    = 20
) (
  input  logic          clk,
  input  logic          rst,
  score_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PLAYING = 2'b01,
    OVER    = 2'b10
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] score_1_q, score_1_d;
  logic [15:0] score_2_q, score_2_d;
  logic [15:0] high_q, high_d;
  logic [1:0]  winner_q, winner_d;
  logic        round_over_q;
  logic        enter_over;

  logic [16:0] sum_1, sum_2;
  logic [15:0] inc_1, inc_2;
  logic        reach_1, reach_2;

  // Sums are one bit wider than the score so saturation never sees a wrapped value
  always_comb begin
    sum_1 = {1'b0, score_1_q}
          + (bus.eat_1   ? 17'(FOOD_POINTS)  : 17'd0)
          + (bus.bonus_1 ? 17'(BONUS_POINTS) : 17'd0);
    sum_2 = {1'b0, score_2_q}
          + (bus.eat_2   ? 17'(FOOD_POINTS)  : 17'd0)
          + (bus.bonus_2 ? 17'(BONUS_POINTS) : 17'd0);
    inc_1   = (sum_1 > 17'(MAX_SCORE)) ? 16'(MAX_SCORE) : sum_1[15:0];
    inc_2   = (sum_2 > 17'(MAX_SCORE)) ? 16'(MAX_SCORE) : sum_2[15:0];
    reach_1 = (inc_1 >= 16'(WIN_SCORE));
    reach_2 = (inc_2 >= 16'(WIN_SCORE));
  end

  always_comb begin
    state_d    = state_q;
    score_1_d  = score_1_q;
    score_2_d  = score_2_q;
    winner_d   = winner_q;
    enter_over = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.game_start) begin
          state_d   = PLAYING;
          score_1_d = '0;
          score_2_d = '0;
          winner_d  = WIN_NONE;
        end
      end
      PLAYING: begin
        if (bus.game_start) begin
          score_1_d = '0;
          score_2_d = '0;
          winner_d  = WIN_NONE;
        end else if (bus.crash_1 || bus.crash_2) begin
          // A crash freezes both scores; the survivor wins, a double crash goes on points
          state_d    = OVER;
          enter_over = 1'b1;
          if (bus.crash_1 && bus.crash_2) begin
            if (score_1_q > score_2_q)      winner_d = WIN_P1;
            else if (score_2_q > score_1_q) winner_d = WIN_P2;
            else                            winner_d = WIN_DRAW;
          end else if (bus.crash_1) begin
            winner_d = WIN_P2;
          end else begin
            winner_d = WIN_P1;
          end
        end else begin
          score_1_d = inc_1;
          score_2_d = inc_2;
          if (reach_1 || reach_2) begin
            state_d    = OVER;
            enter_over = 1'b1;
            if (reach_1 && reach_2) begin
              if (inc_1 > inc_2)      winner_d = WIN_P1;
              else if (inc_2 > inc_1) winner_d = WIN_P2;
              else                    winner_d = WIN_DRAW;
            end else if (reach_1) begin
              winner_d = WIN_P1;
            end else begin
              winner_d = WIN_P2;
            end
          end
        end
      end
      OVER: begin
        if (bus.game_start) begin
          state_d   = PLAYING;
          score_1_d = '0;
          score_2_d = '0;
          winner_d  = WIN_NONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // High score looks at the final scores registered on the edge that ends the round
  always_comb begin
    high_d = high_q;
    if (enter_over) begin
      if (score_1_d > high_d) high_d = score_1_d;
      if (score_2_d > high_d) high_d = score_2_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      score_1_q    <= '0;
      score_2_q    <= '0;
      high_q       <= '0;
      winner_q     <= WIN_NONE;
      round_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_1_q    <= score_1_d;
      score_2_q    <= score_2_d;
      high_q       <= high_d;
      winner_q     <= winner_d;
      round_over_q <= enter_over;
    end
  end

  assign bus.score_1    = score_1_q;
  assign bus.score_2    = score_2_q;
  assign bus.high_score = high_q;
  assign bus.state      = state_q;
  assign bus.winner     = winner_q;
  assign bus.round_over = round_over_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: one instance at the default target of 20, one at 99 for saturation.
module tb_score_keeper;

  localparam logic [6:0] EV_START  = 7'b1000000;
  localparam logic [6:0] EV_EAT1   = 7'b0100000;
  localparam logic [6:0] EV_EAT2   = 7'b0010000;
  localparam logic [6:0] EV_BONUS1 = 7'b0001000;
  localparam logic [6:0] EV_BONUS2 = 7'b0000100;
  localparam logic [6:0] EV_CRASH1 = 7'b0000010;
  localparam logic [6:0] EV_CRASH2 = 7'b0000001;
  localparam logic [6:0] EV_NONE   = 7'b0000000;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  score_keeper_if bus_a ();
  score_keeper_if bus_b ();

  score_keeper #(.WIN_SCORE(20)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  score_keeper #(.WIN_SCORE(99)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Events are held for exactly one rising edge, then outputs are sampled 1 time unit later
  task automatic apply_stimulus_a(input logic [6:0] ev);
    {bus_a.game_start, bus_a.eat_1, bus_a.eat_2, bus_a.bonus_1,
     bus_a.bonus_2, bus_a.crash_1, bus_a.crash_2} = ev;
    @(posedge clk);
    #1;
    {bus_a.game_start, bus_a.eat_1, bus_a.eat_2, bus_a.bonus_1,
     bus_a.bonus_2, bus_a.crash_1, bus_a.crash_2} = EV_NONE;
  endtask

  task automatic apply_stimulus_b(input logic [6:0] ev);
    {bus_b.game_start, bus_b.eat_1, bus_b.eat_2, bus_b.bonus_1,
     bus_b.bonus_2, bus_b.crash_1, bus_b.crash_2} = ev;
    @(posedge clk);
    #1;
    {bus_b.game_start, bus_b.eat_1, bus_b.eat_2, bus_b.bonus_1,
     bus_b.bonus_2, bus_b.crash_1, bus_b.crash_2} = EV_NONE;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    {bus_a.game_start, bus_a.eat_1, bus_a.eat_2, bus_a.bonus_1,
     bus_a.bonus_2, bus_a.crash_1, bus_a.crash_2} = EV_NONE;
    {bus_b.game_start, bus_b.eat_1, bus_b.eat_2, bus_b.bonus_1,
     bus_b.bonus_2, bus_b.crash_1, bus_b.crash_2} = EV_NONE;
    #2;
    check_output("reset score_1",    bus_a.score_1, 16'd0);
    check_output("reset score_2",    bus_a.score_2, 16'd0);
    check_output("reset high_score", bus_a.high_score, 16'd0);
    check_output("reset state",      16'(bus_a.state), 16'd0);
    check_output("reset winner",     16'(bus_a.winner), 16'd0);
    check_output("reset round_over", 16'(bus_a.round_over), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    apply_stimulus_a(EV_EAT1);
    check_output("idle eat score_1", bus_a.score_1, 16'd0);
    check_output("idle eat state",   16'(bus_a.state), 16'd0);

    apply_stimulus_a(EV_START);
    check_output("start state", 16'(bus_a.state), 16'd1);
    apply_stimulus_a(EV_EAT1);
    check_output("first eat score_1", bus_a.score_1, 16'd1);
    apply_stimulus_a(EV_EAT1);
    apply_stimulus_a(EV_EAT1);
    apply_stimulus_a(EV_BONUS2);
    check_output("basic score_1", bus_a.score_1, 16'd3);
    check_output("basic score_2", bus_a.score_2, 16'd5);
    check_output("basic state",   16'(bus_a.state), 16'd1);
    check_output("basic winner",  16'(bus_a.winner), 16'd0);

    // Restart mid-round, then build 7/4 and double-crash with a dropped eat_2
    apply_stimulus_a(EV_START);
    check_output("restart score_1", bus_a.score_1, 16'd0);
    check_output("restart score_2", bus_a.score_2, 16'd0);
    apply_stimulus_a(EV_EAT1 | EV_BONUS1);
    check_output("eat+bonus score_1", bus_a.score_1, 16'd6);
    apply_stimulus_a(EV_EAT1);
    for (int i = 0; i < 4; i++) apply_stimulus_a(EV_EAT2);
    check_output("pre-crash score_1", bus_a.score_1, 16'd7);
    check_output("pre-crash score_2", bus_a.score_2, 16'd4);
    apply_stimulus_a(EV_CRASH1 | EV_CRASH2 | EV_EAT2);
    check_output("double crash state",      16'(bus_a.state), 16'd2);
    check_output("double crash winner",     16'(bus_a.winner), 16'd1);
    check_output("double crash score_2",    bus_a.score_2, 16'd4);
    check_output("double crash high_score", bus_a.high_score, 16'd7);
    check_output("double crash round_over", 16'(bus_a.round_over), 16'd1);
    apply_stimulus_a(EV_EAT1);
    check_output("over round_over drop", 16'(bus_a.round_over), 16'd0);
    check_output("over eat ignored",     bus_a.score_1, 16'd7);

    apply_stimulus_a(EV_START);
    check_output("over restart score_1", bus_a.score_1, 16'd0);
    check_output("over restart score_2", bus_a.score_2, 16'd0);
    check_output("over restart winner",  16'(bus_a.winner), 16'd0);
    check_output("over restart state",   16'(bus_a.state), 16'd1);
    check_output("over restart high",    bus_a.high_score, 16'd7);

    // Both at 18, then simultaneous bonuses cross 20 together for a draw
    for (int i = 0; i < 3; i++) apply_stimulus_a(EV_BONUS1 | EV_BONUS2);
    for (int i = 0; i < 3; i++) apply_stimulus_a(EV_EAT1 | EV_EAT2);
    check_output("18 score_1", bus_a.score_1, 16'd18);
    check_output("18 state",   16'(bus_a.state), 16'd1);
    apply_stimulus_a(EV_BONUS1 | EV_BONUS2);
    check_output("draw score_1",    bus_a.score_1, 16'd23);
    check_output("draw score_2",    bus_a.score_2, 16'd23);
    check_output("draw winner",     16'(bus_a.winner), 16'd3);
    check_output("draw state",      16'(bus_a.state), 16'd2);
    check_output("draw high_score", bus_a.high_score, 16'd23);

    apply_stimulus_a(EV_START);
    apply_stimulus_a(EV_EAT2);
    apply_stimulus_a(EV_CRASH1);
    check_output("crash_1 winner", 16'(bus_a.winner), 16'd2);
    check_output("crash_1 high",   bus_a.high_score, 16'd23);

    // P1 alone lands exactly on the target
    apply_stimulus_a(EV_START);
    for (int i = 0; i < 3; i++) apply_stimulus_a(EV_BONUS1);
    check_output("15 state", 16'(bus_a.state), 16'd1);
    apply_stimulus_a(EV_BONUS1);
    check_output("exact win state",  16'(bus_a.state), 16'd2);
    check_output("exact win winner", 16'(bus_a.winner), 16'd1);

    // Saturation on the WIN_SCORE=99 instance
    apply_stimulus_b(EV_START);
    for (int i = 0; i < 19; i++) apply_stimulus_b(EV_BONUS1);
    apply_stimulus_b(EV_EAT1);
    check_output("b 96 score_1", bus_b.score_1, 16'd96);
    check_output("b 96 state",   16'(bus_b.state), 16'd1);
    apply_stimulus_b(EV_EAT1 | EV_BONUS1);
    check_output("b sat score_1",    bus_b.score_1, 16'd99);
    check_output("b sat state",      16'(bus_b.state), 16'd2);
    check_output("b sat winner",     16'(bus_b.winner), 16'd1);
    check_output("b sat round_over", 16'(bus_b.round_over), 16'd1);
    check_output("b sat high_score", bus_b.high_score, 16'd99);
    apply_stimulus_b(EV_EAT1);
    check_output("b hold score_1",    bus_b.score_1, 16'd99);
    check_output("b round_over once", 16'(bus_b.round_over), 16'd0);

    // Asynchronous reset between edges mid-round
    apply_stimulus_a(EV_START);
    apply_stimulus_a(EV_BONUS1);
    apply_stimulus_a(EV_BONUS1);
    apply_stimulus_a(EV_EAT1);
    apply_stimulus_a(EV_EAT1);
    check_output("pre-reset score_1", bus_a.score_1, 16'd12);
    #2;
    rst = 1'b1;
    #1;
    check_output("async score_1", bus_a.score_1, 16'd0);
    check_output("async state",   16'(bus_a.state), 16'd0);
    check_output("async high",    bus_a.high_score, 16'd0);
    check_output("async winner",  16'(bus_a.winner), 16'd0);
    check_output("async b score", bus_b.score_1, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus_a(EV_NONE);
    check_output("post reset state", 16'(bus_a.state), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Upstream source of the two 16-bit score buses consumed by the 7-segment score display. Accumulates per-player points from single-cycle game events (food, bonus), runs the round state machine (IDLE/PLAYING/OVER), decides the winner on crash or target score, and keeps a session high score. All outputs are registered, so the display always reads glitch-free, in-range values.

Parameters:
MAX_SCORE, 99, saturation ceiling; display shows two digits per player.
FOOD_POINTS, 1, points per eat_x pulse.
BONUS_POINTS, 5, points per bonus_x pulse.
WIN_SCORE, 20, score at or above which a round ends. Legal range 1..MAX_SCORE.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
game_start  input  1  one-cycle pulse; begins a new round
eat_1  input  1  one-cycle pulse; player 1 ate food
eat_2  input  1  one-cycle pulse; player 2 ate food
bonus_1  input  1  one-cycle pulse; player 1 took a bonus
bonus_2  input  1  one-cycle pulse; player 2 took a bonus
crash_1  input  1  one-cycle pulse; player 1 crashed
crash_2  input  1  one-cycle pulse; player 2 crashed
score_1  output  16  player 1 score, 0..MAX_SCORE
score_2  output  16  player 2 score, 0..MAX_SCORE
high_score  output  16  best single-player score of any finished round since reset
state  output  2  00 IDLE, 01 PLAYING, 10 OVER
winner  output  2  00 none, 01 P1, 10 P2, 11 draw
round_over  output  1  one-cycle pulse on entering OVER

Behaviour:
- Reset, asynchronous on rst high: score_1, score_2 and high_score = 0; state = IDLE; winner = 00; round_over = 0.
- All state and outputs update on the rising edge of clk. An event sampled at edge N is visible at edge N, i.e. one-cycle latency.
- Transitions:
  - IDLE: game_start -> PLAYING. All other inputs are ignored.
  - PLAYING, on game_start: the round restarts. Scores clear to 0, winner clears to 00, state stays PLAYING. All same-cycle events are dropped.
  - PLAYING, on crash_1 or crash_2, without game_start: -> OVER.
    - crash_1 only: winner = 10.
    - crash_2 only: winner = 01.
    - Both: the higher current score wins; equal scores give 11.
    - All eat/bonus events in a crash cycle are dropped. Scores freeze at their pre-crash values.
  - PLAYING, with no crash and no game_start:
    - next_score_x = min(score_x + FOOD_POINTS*eat_x + BONUS_POINTS*bonus_x, MAX_SCORE).
    - Eat and bonus in the same cycle for the same player both count.
    - Compute the sum at a width of at least 17 bits before saturating; no wrap-around ever.
  - Win check on the updated values, same edge: if either next score >= WIN_SCORE, go to OVER.
    - Only P1 reached it: winner = 01. Only P2 reached it: winner = 10.
    - Both reached it: the higher next score wins; equal gives 11.
  - OVER: scores and winner hold. game_start -> PLAYING with scores and winner cleared. Events are ignored.
- round_over is high for exactly the one cycle following the transition into OVER.
- high_score update, on the edge that enters OVER:
  - high_score <= max(high_score, final score_1, final score_2), where final scores are the values registered on that edge.
  - high_score is cleared only by rst; game_start does not clear it.
- Bits [15:7] of score_1 and score_2 are always 0 when MAX_SCORE <= 127.
- Reset asserted mid-round forces IDLE immediately. No pending event survives the reset.

Test Plan:
- Reset, then game_start, then 3 eat_1 pulses and 1 bonus_2 pulse -> score_1 = 3, score_2 = 5, state = 01, winner = 00. Each score updates one cycle after its pulse.
- Same-cycle eat_1 + bonus_1 at score_1 = 96 -> score_1 = 99 (saturated), not 102. A further eat_1 keeps 99. With WIN_SCORE = 99 the bench instead sees state = 10, winner = 01 and a single round_over pulse.
- score_1 = 7, score_2 = 4, then crash_1 and crash_2 in the same cycle together with eat_2 -> state = 10, winner = 01, score_2 stays 4, high_score = 7.
- score_1 = score_2 = 18, then bonus_1 + bonus_2 simultaneously (WIN_SCORE = 20) -> both scores 23, winner = 11, state = 10, high_score = 23.
- In OVER, pulse game_start -> scores 0, winner 00, state 01, high_score retained. Pulse eat_1 while in IDLE -> no change.
- Mid-round with score_1 = 12, assert rst asynchronously between clock edges -> all outputs 0 and state 00 immediately, without waiting for a clk edge.
